// File: rtl/sophon_pkg.sv
// Shared definitions for the instruction fetch bridge: FSM state encoding
// and timeout counter width.
package sophon_pkg;

   localparam int TMO_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HIT   = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ACK   = 3'd4,
      ST_DRAIN = 3'd5
   } fetch_state_e;

endpackage

// File: rtl/inst_pos_fetch_bridge.sv
// Instruction fetch bridge: turns level fetch requests into single bus reads,
// with a one-entry fetch buffer and a per-fetch timeout.
module inst_pos_fetch_bridge
   import sophon_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit BUF_EN         = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inst_pos_req_i,
   input  logic [31:0]  inst_pos_addr_i,
   output logic         inst_pos_ack_o,
   output logic [31:0]  inst_pos_data_o,
   output logic         inst_pos_error_o,
   input  logic         flush_i,
   output logic         bus_req_o,
   output logic [31:0]  bus_addr_o,
   input  logic         bus_gnt_i,
   input  logic         bus_rvalid_i,
   input  logic [31:0]  bus_rdata_i,
   input  logic         bus_err_i,
   output fetch_state_e dbg_state_o
);

   // Handshakes: upstream holds req as a level and gets exactly one ack pulse
   // per accepted fetch (none if req is withdrawn before the response). The bus
   // side holds req/addr stable until gnt, then expects one rvalid per grant;
   // bus_err_i is only meaningful while bus_rvalid_i is high.

   // The acceptance cycle counts toward the budget, so the error ack appears
   // TIMEOUT_CYCLES cycles after acceptance; the counter lags by two.
   localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES - 2);

   fetch_state_e           state_q, state_d;
   logic [29:0]            addr_q, addr_d;
   logic [TMO_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic                   ack_q, ack_d;
   logic [31:0]            data_q, data_d;
   logic                   err_q, err_d;
   logic                   breq_q, breq_d;
   logic [31:0]            baddr_q, baddr_d;
   logic                   buf_valid_q;
   logic [29:0]            buf_tag_q;
   logic [31:0]            buf_data_q;
   logic                   buf_wr;
   logic                   buf_hit;
   logic                   tmo;
   logic                   addr_lsb_unused;

   assign addr_lsb_unused = ^inst_pos_addr_i[1:0];

   assign buf_hit = BUF_EN && buf_valid_q && (buf_tag_q == inst_pos_addr_i[31:2]);
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 8'd1;
   assign tmo     = (cnt_q >= TMO_LIMIT);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      data_d  = data_q;
      err_d   = err_q;
      breq_d  = breq_q;
      baddr_d = baddr_q;
      buf_wr  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (inst_pos_req_i) begin
               addr_d = inst_pos_addr_i[31:2];
               cnt_d  = '0;
               if (buf_hit) begin
                  state_d = ST_HIT;
                  ack_d   = 1'b1;
                  data_d  = buf_data_q;
                  err_d   = 1'b0;
               end else begin
                  state_d = ST_REQ;
                  breq_d  = 1'b1;
                  baddr_d = {inst_pos_addr_i[31:2], 2'b00};
               end
            end
         end
         ST_HIT, ST_ACK: state_d = ST_IDLE;
         ST_REQ: begin
            cnt_d = cnt_inc;
            if (bus_gnt_i) begin
               breq_d  = 1'b0;
               state_d = ST_WAIT;
            end else if (tmo) begin
               breq_d  = 1'b0;
               ack_d   = 1'b1;
               data_d  = '0;
               err_d   = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            // A response arriving on the timeout cycle still completes normally.
            if (bus_rvalid_i) begin
               buf_wr = !bus_err_i;
               if (inst_pos_req_i) begin
                  ack_d   = 1'b1;
                  data_d  = bus_err_i ? '0 : bus_rdata_i;
                  err_d   = bus_err_i;
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (tmo) begin
               ack_d   = 1'b1;
               data_d  = '0;
               err_d   = 1'b1;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus_rvalid_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
         breq_q  <= 1'b0;
         baddr_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         err_q   <= err_d;
         breq_q  <= breq_d;
         baddr_q <= baddr_d;
      end
   end

   // Flush takes priority over a same-cycle fill.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
      end else begin
         if (buf_wr) begin
            buf_tag_q  <= addr_q;
            buf_data_q <= bus_rdata_i;
         end
         if (flush_i)     buf_valid_q <= 1'b0;
         else if (buf_wr) buf_valid_q <= 1'b1;
      end
   end

   assign inst_pos_ack_o   = ack_q;
   assign inst_pos_data_o  = data_q;
   assign inst_pos_error_o = err_q;
   assign bus_req_o        = breq_q;
   assign bus_addr_o       = baddr_q;
   assign dbg_state_o      = state_q;

endmodule

// File: doc/inst_pos_fetch_bridge.md
INST_POS_FETCH_BRIDGE -- requirements
Module: inst_pos_fetch_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum bus cycles per fetch before an error is returned.
REQ-002 Parameter BUF_EN, default 1: 1 enables the single-entry fetch buffer; 0 sends every fetch to the bus.
REQ-003 clk_i  input  1  the only clock; all flops clock on its posedge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 inst_pos_req_i  input  1  level fetch request from the upstream demux.
REQ-006 inst_pos_addr_i  input  32  fetch byte address.
REQ-007 inst_pos_ack_o  output  1  one-cycle completion pulse.
REQ-008 inst_pos_data_o  output  32  instruction word; valid while ack is high.
REQ-009 inst_pos_error_o  output  1  fetch error; valid while ack is high.
REQ-010 flush_i  input  1  invalidates the fetch buffer (fence.i).
REQ-011 bus_req_o  output  1  bus read request.
REQ-012 bus_addr_o  output  32  word-aligned bus address.
REQ-013 bus_gnt_i  input  1  request accepted.
REQ-014 bus_rvalid_i  input  1  response valid.
REQ-015 bus_rdata_i  input  32  response data.
REQ-016 bus_err_i  input  1  response error; qualified by rvalid.

Function
REQ-017 All outputs shall be registered.
REQ-018 FSM states: IDLE, HIT, REQ, WAIT, ACK, DRAIN.
REQ-019 IDLE with req=1: latch addr; buffer hit (BUF_EN, entry valid, tag == addr[31:2]) -> HIT; otherwise -> REQ with bus_req_o=1 and bus_addr_o={addr[31:2],2'b00}.
REQ-020 Address changes after acceptance shall be ignored until the next return to IDLE.
REQ-021 HIT: ack=1, data=buffer data, error=0 for exactly one cycle, then IDLE; hit latency is req-sampled edge N to ack high in cycle N+1.
REQ-022 REQ: hold bus_req_o and bus_addr_o stable until bus_gnt_i; on gnt, drop bus_req_o and go to WAIT.
REQ-023 WAIT with rvalid and req=1: register data=bus_rdata_i and error=bus_err_i, then go to ACK.
REQ-024 On a bus error, data shall be 32'h0.
REQ-025 ACK: ack=1 for exactly one cycle, then IDLE.
REQ-026 Ack shall never be high for two consecutive cycles.
REQ-027 Miss latency: grant on the first REQ cycle plus rvalid on the first WAIT cycle gives ack 3 cycles after acceptance.
REQ-028 Upstream withdrawal: if req=0 when rvalid arrives, no ack shall be issued; the buffer updates normally; go to IDLE.
REQ-029 Buffer write on rvalid with bus_err_i=0: tag = latched addr[31:2], data = bus_rdata_i, valid=1.
REQ-030 A bus error shall not write the buffer.
REQ-031 flush_i clears the buffer valid bit in the next cycle; flush coincident with a buffer write: flush wins.
REQ-032 flush_i during HIT shall not alter that in-flight ack.
REQ-033 Timeout: an 8-bit saturating counter clears on acceptance and increments in REQ and WAIT.
REQ-034 Counter reaching TIMEOUT_CYCLES in REQ: drop bus_req_o, ack with error=1 and data=0, go to ACK.
REQ-035 Counter reaching TIMEOUT_CYCLES in WAIT: ack with error=1 and data=0, go to DRAIN.
REQ-036 DRAIN: wait for rvalid, discard the response without a buffer write or ack, then IDLE; new requests wait in DRAIN.
REQ-037 Timeout and rvalid in the same cycle: rvalid wins.

Reset
REQ-038 Reset state: state=IDLE, bus_req_o=0, bus_addr_o=0, inst_pos_ack_o=0, inst_pos_data_o=0, inst_pos_error_o=0, buffer valid=0, counter=0.
REQ-039 Reset mid-transaction shall abandon the fetch; after reset release, the first rvalid shall be ignored unless state is WAIT or DRAIN.

Structure
REQ-040 State enum and the timeout counter width shall live in the shared package sophon_pkg.
REQ-041 Single module, no sub-module; buffer and counter inline.

Verification
REQ-042 Miss: req, addr 0x0000_0104; gnt in 1 cycle, rvalid in 1 cycle with 0x0001_0113 -> bus_addr 0x104, ack 3 cycles after acceptance, data 0x0001_0113, error 0.
REQ-043 Repeat 0x104 with no flush -> no bus_req, ack next cycle, data 0x0001_0113; then flush_i pulse and fetch 0x104 again -> bus_req_o asserted.
REQ-044 bus_err_i=1 on rvalid for 0x200 -> ack with error 1 and data 0; a refetch of 0x200 misses.
REQ-045 gnt never arrives, TIMEOUT_CYCLES=8 -> bus_req drops and ack error=1 is issued 8 cycles after acceptance.
REQ-046 Timeout in WAIT, then rvalid arrives 3 cycles later -> no second ack, buffer unchanged; the next request is accepted only after that rvalid.
REQ-047 req deasserted while in WAIT, rvalid arrives -> no ack; a following fetch of the same address hits.
